// File: rtl/poly_coeff_mac_buffer.sv
// poly_coeff_mac_buffer: streaming modular multiply/accumulate engine with an
// N-entry on-chip result buffer and an indexed drain port.
// Pipeline: accept (t) -> product (t+1) -> reduce + buffer read (t+2) -> write (t+3).
module poly_coeff_mac_buffer #(
    parameter int N  = 256,
    parameter int W  = 12,
    parameter int Q  = 3329,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          acc,
    input  logic          rd,
    input  logic          int_valid,  // input-valid strobe ("int" is a reserved word)
    input  logic [W-1:0]  in1,
    input  logic [W-1:0]  in2,
    output logic          busy,
    output logic          pass_done,
    output logic          out_valid,
    output logic [AW-1:0] out_idx,
    output logic [W-1:0]  final_output,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    localparam logic [W-1:0]   QW = W'(Q);
    // Barrett constant floor(2^(2W)/Q); estimate is at most one Q short.
    localparam logic [2*W-1:0] MU = (2*W)'((64'd1 << (2*W)) / 64'(Q));

    state_t          state;
    logic            acc_q;
    logic [AW-1:0]   k;
    logic [AW:0]     dcnt;
    logic            rv;
    logic [AW-1:0]   ridx;

    logic            v1, v2, v3;
    logic [W-1:0]    a1, b1;
    logic [AW-1:0]   k1, k2, k3;
    logic [2*W-1:0]  prod2;
    logic [W-1:0]    p3;
    logic [W-1:0]    rdq;

    logic [W-1:0]    mem [N];
    logic [AW-1:0]   raddr;

    logic [2*W-1:0]  bqest;
    logic [W:0]      brem;
    logic [W-1:0]    pmod;
    logic [W:0]      sum;
    logic [W-1:0]    wdata;

    assign busy = (state != IDLE);

    // Barrett reduction of the registered product and modular accumulate
    always_comb begin
        bqest = (2*W)'(((4*W)'(prod2) * (4*W)'(MU)) >> (2*W));
        brem  = (W+1)'(prod2 - (2*W)'(bqest * (2*W)'(QW)));
        pmod  = (brem >= {1'b0, QW}) ? W'(brem - {1'b0, QW}) : brem[W-1:0];
        sum   = {1'b0, rdq} + {1'b0, p3};
        if (acc_q)
            wdata = (sum >= {1'b0, QW}) ? W'(sum - {1'b0, QW}) : sum[W-1:0];
        else
            wdata = p3;
    end

    // Single read port: pipeline read during a pass, drain address otherwise
    always_comb begin
        raddr = k2;
        if (state == DRAIN)
            raddr = dcnt[AW-1:0];
        else if (state == IDLE)
            raddr = '0;
    end

    // Buffer RAM: synchronous read, write gated off on the reset edge
    always_ff @(posedge clk) begin
        rdq <= mem[raddr];
        if (!rst && v3)
            mem[k3] <= wdata;
    end

    // Datapath pipeline registers (qualified by v1..v3)
    always_ff @(posedge clk) begin
        a1    <= in1;
        b1    <= in2;
        k1    <= k;
        prod2 <= (2*W)'(a1) * (2*W)'(b1);
        k2    <= k1;
        p3    <= pmod;
        k3    <= k2;
    end

    // Control FSM with registered status and drain outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc_q        <= 1'b0;
            k            <= '0;
            dcnt         <= '0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            v3           <= 1'b0;
            rv           <= 1'b0;
            ridx         <= '0;
            pass_done    <= 1'b0;
            out_valid    <= 1'b0;
            done         <= 1'b0;
            out_idx      <= '0;
            final_output <= '0;
        end else begin
            pass_done <= 1'b0;
            v1        <= 1'b0;
            v2        <= v1;
            v3        <= v2;
            rv        <= 1'b0;
            out_valid <= rv;
            done      <= rv && (ridx == AW'(N-1));
            if (rv) begin
                final_output <= rdq;
                out_idx      <= ridx;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        acc_q <= acc;
                        k     <= '0;
                    end else if (rd) begin
                        state <= DRAIN;
                        rv    <= 1'b1;
                        ridx  <= '0;
                        dcnt  <= (AW+1)'(1);
                    end
                end
                LOAD: begin
                    if (int_valid) begin
                        v1 <= 1'b1;
                        k  <= k + AW'(1);
                        if (k == AW'(N-1))
                            state <= FLUSH;
                    end
                end
                FLUSH: begin
                    // only the final write remains once v1/v2 have emptied
                    if (v3 && !v2 && !v1) begin
                        pass_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
                DRAIN: begin
                    if (dcnt != (AW+1)'(N)) begin
                        rv   <= 1'b1;
                        ridx <= dcnt[AW-1:0];
                        dcnt <= dcnt + (AW+1)'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_coeff_mac_buffer.sv
// Testbench for poly_coeff_mac_buffer: table-driven passes and drains checked
// against a behavioural buffer model, plus reset and random corner sequences.
module tb_poly_coeff_mac_buffer;

    localparam int N  = 256;
    localparam int W  = 12;
    localparam int Q  = 3329;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst, start, acc, rd, int_valid;
    logic [W-1:0]  in1, in2;
    logic          busy, pass_done, out_valid, done;
    logic [AW-1:0] out_idx;
    logic [W-1:0]  final_output;

    poly_coeff_mac_buffer #(.N(N), .W(W), .Q(Q)) dut (
        .clk(clk), .rst(rst), .start(start), .acc(acc), .rd(rd),
        .int_valid(int_valid), .in1(in1), .in2(in2), .busy(busy),
        .pass_done(pass_done), .out_valid(out_valid), .out_idx(out_idx),
        .final_output(final_output), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int pd_cnt = 0;
    int ov_cnt = 0;

    int unsigned model [N];
    int unsigned a_in  [N];
    int unsigned b_in  [N];

    typedef struct {
        int pat;
        bit a;
        bit gaps;
        bit both;
        int e0;
        int e1;
        int el;
    } vec_t;

    vec_t vt [6];

    task automatic tick();
        @(negedge clk);
        if (pass_done) pd_cnt++;
        if (out_valid) ov_cnt++;
    endtask

    task automatic chk(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic fill(input int pat);
        for (int k = 0; k < N; k++) begin
            case (pat)
                0: begin a_in[k] = k + 1;     b_in[k] = k + 257; end
                1: begin a_in[k] = 3328;      b_in[k] = 3328;    end
                2: begin a_in[k] = 3328;      b_in[k] = 1;       end
                3: begin a_in[k] = 4095;      b_in[k] = 1;       end
                default: begin
                    a_in[k] = $urandom_range(0, 4095);
                    b_in[k] = $urandom_range(0, 4095);
                end
            endcase
        end
    endtask

    task automatic apply_model(input bit a_mode, input int cnt);
        int unsigned p;
        for (int k = 0; k < cnt; k++) begin
            p = (a_in[k] * b_in[k]) % Q;
            model[k] = a_mode ? (model[k] + p) % Q : p;
        end
    endtask

    task automatic run_pass(input bit a_mode, input bit gaps, input bit both);
        int s, last, pd0, ov0;
        bit got;
        pd0 = pd_cnt;
        ov0 = ov_cnt;
        start = 1'b1; acc = a_mode; rd = both; int_valid = 1'b0;
        tick();
        start = 1'b0; rd = 1'b0;
        s = cyc;
        last = s;
        chk("busy_in_load", busy, 1);
        for (int k = 0; k < N; ) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                int_valid = 1'b0;
                in1 = W'($urandom);
                in2 = W'($urandom);
                start = 1'($urandom_range(0, 1));
                rd = 1'($urandom_range(0, 1));
            end else begin
                int_valid = 1'b1;
                in1 = W'(a_in[k]);
                in2 = W'(b_in[k]);
                start = 1'b0;
                rd = 1'b0;
                k++;
            end
            tick();
            if (int_valid) last = cyc;
        end
        chk("no_early_pass_done", pd_cnt - pd0, 0);
        got = 1'b0;
        for (int w = 0; w < 40 && !got; w++) begin
            if (w < 2) begin
                int_valid = 1'b1;
                in1 = W'($urandom);
                in2 = W'($urandom);
            end else begin
                int_valid = 1'b0;
            end
            tick();
            if (pass_done) got = 1'b1;
        end
        int_valid = 1'b0;
        chk("pass_done_seen", int'(got), 1);
        if (got) begin
            chk("pass_done_latency", cyc - last, 3);
            if (!gaps) chk("pass_length", cyc - s, N + 3);
            tick();
            chk("pass_done_one_cycle", pass_done, 0);
            chk("idle_after_pass", busy, 0);
        end
        chk("pass_done_pulses", pd_cnt - pd0, 1);
        chk("no_spurious_drain", ov_cnt - ov0, 0);
        apply_model(a_mode, N);
    endtask

    task automatic drain(output int d0, output int d1, output int dl);
        int t, bad, badi, bgot, bexp, bidx, bdone;
        bit ok;
        d0 = -1; d1 = -1; dl = -1;
        rd = 1'b1;
        tick();
        rd = 1'b0;
        t = cyc;
        chk("busy_in_drain", busy, 1);
        chk("no_valid_at_rd_edge", out_valid, 0);
        ok = 1'b0;
        for (int w = 0; w < 8 && !ok; w++) begin
            tick();
            if (out_valid) ok = 1'b1;
        end
        chk("drain_started", int'(ok), 1);
        if (!ok) return;
        chk("first_valid_latency", cyc - t, 1);
        bad = 0; badi = -1; bgot = 0; bexp = 0; bidx = 0; bdone = 0;
        for (int i = 0; i < N; i++) begin
            if (!out_valid || out_idx != AW'(i)) bidx++;
            if (done != (i == N - 1)) bdone++;
            if (final_output != W'(model[i])) begin
                if (badi < 0) begin
                    badi = i; bgot = final_output; bexp = model[i];
                end
                bad++;
            end
            if (i == 0) d0 = final_output;
            if (i == 1) d1 = final_output;
            if (i == N - 1) dl = final_output;
            tick();
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL drain_data: %0d entries differ, first idx %0d got %0d expected %0d",
                     bad, badi, bgot, bexp);
        end
        chk("drain_idx_errors", bidx, 0);
        chk("drain_done_errors", bdone, 0);
        chk("valid_low_after_drain", out_valid, 0);
        chk("done_low_after_drain", done, 0);
        chk("idle_after_drain", busy, 0);
        chk("idx_holds", out_idx, N - 1);
        chk("data_holds", final_output, model[N-1]);
    endtask

    initial begin
        int d0, d1, dl, s, r, nw;

        vt[0] = '{pat: 0, a: 1'b0, gaps: 1'b0, both: 1'b0, e0: 257, e1: 516,  el: 1241};
        vt[1] = '{pat: 0, a: 1'b1, gaps: 1'b0, both: 1'b0, e0: 514, e1: 1032, el: 2482};
        vt[2] = '{pat: 1, a: 1'b0, gaps: 1'b0, both: 1'b0, e0: 1,   e1: 1,    el: 1};
        vt[3] = '{pat: 2, a: 1'b1, gaps: 1'b0, both: 1'b0, e0: 0,   e1: 0,    el: 0};
        vt[4] = '{pat: 3, a: 1'b0, gaps: 1'b0, both: 1'b0, e0: 766, e1: 766,  el: 766};
        vt[5] = '{pat: 0, a: 1'b0, gaps: 1'b1, both: 1'b1, e0: 257, e1: 516,  el: 1241};

        rst = 1'b1; start = 1'b0; acc = 1'b0; rd = 1'b0; int_valid = 1'b0;
        in1 = '0; in2 = '0;
        for (int k = 0; k < N; k++) model[k] = 0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_pass_done", pass_done, 0);
        chk("rst_final_output", final_output, 0);
        chk("rst_out_idx", out_idx, 0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            fill(vt[v].pat);
            run_pass(vt[v].a, vt[v].gaps, vt[v].both);
            tick();
            drain(d0, d1, dl);
            chk($sformatf("row%0d_idx0", v), d0, vt[v].e0);
            chk($sformatf("row%0d_idx1", v), d1, vt[v].e1);
            chk($sformatf("row%0d_idxlast", v), dl, vt[v].el);
            if (v == 0) begin
                drain(d0, d1, dl);
                chk("redrain_idx0", d0, vt[v].e0);
            end
        end

        // reset after 100 accepted pairs: only writes before the reset edge land
        fill(1);
        start = 1'b1; acc = 1'b0;
        tick();
        start = 1'b0;
        s = cyc;
        for (int k = 0; k < 100; k++) begin
            int_valid = 1'b1;
            in1 = W'(a_in[k]);
            in2 = W'(b_in[k]);
            tick();
        end
        int_valid = 1'b0;
        rst = 1'b1;
        tick();
        r = cyc;
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_pass_done", pass_done, 0);
        chk("midrst_out_valid", out_valid, 0);
        nw = 0;
        for (int k = 0; k < 100; k++)
            if (s + k + 4 < r) nw = k + 1;
        apply_model(1'b0, nw);
        tick();
        tick();
        drain(d0, d1, dl);
        fill(0);
        run_pass(1'b0, 1'b0, 1'b0);
        drain(d0, d1, dl);
        chk("after_rst_idx0", d0, 257);
        chk("after_rst_idx1", d1, 516);
        chk("after_rst_idxlast", dl, 1241);

        // random data, random mode and gaps
        for (int n = 0; n < 3; n++) begin
            fill(4);
            run_pass(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            drain(d0, d1, dl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
